// File: rtl/branch_predictor_table_if.sv
// Fetch/execute-facing bundle for the branch predictor table.
// master = pipeline side, slave = table side.
interface branch_predictor_table_if #(
    parameter int IDX_W = 5,
    parameter int CTR_W = 2
);
    logic [IDX_W-1:0] read_idx;
    logic             prediction;
    logic [CTR_W-1:0] pred_ctr;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             clear;
    logic             busy;

    modport master (
        output read_idx, upd_valid, upd_idx, upd_taken, clear,
        input  prediction, pred_ctr, pred_idx, busy
    );

    modport slave (
        input  read_idx, upd_valid, upd_idx, upd_taken, clear,
        output prediction, pred_ctr, pred_idx, busy
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Flop-based table of saturating branch counters with a clear sweep.
// Optional gshare index hashing is enabled by defining BPT_GSHARE_EN.
module branch_predictor_table #(
    parameter int ENTRIES  = 32,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 2**(CTR_W-1)-1
) (
    input logic clk,
    input logic rst,
    branch_predictor_table_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT_CTR);
    localparam logic [CTR_W-1:0] MAX_V  = '1;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(ENTRIES-1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [CTR_W-1:0] r_ctr [ENTRIES];

    logic             w_upd_en;
    logic             w_clr_en;
    logic             w_enter_clr;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [CTR_W-1:0] w_upd_old;
    logic [CTR_W-1:0] w_upd_new;
    logic [CTR_W-1:0] w_pred_ctr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Updates and new clear requests are only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_upd_en    = 1'b0;
        w_clr_en    = 1'b0;
        w_enter_clr = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                    w_enter_clr = 1'b1;
                end else if (bus.upd_valid) begin
                    w_upd_en = 1'b1;
                end
            end
            S_CLEAR: begin
                w_clr_en  = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_upd_old = r_ctr[bus.upd_idx];
        w_upd_new = w_upd_old;
        if (bus.upd_taken) begin
            if (w_upd_old != MAX_V) w_upd_new = w_upd_old + 1'b1;
        end else begin
            if (w_upd_old != '0) w_upd_new = w_upd_old - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= INIT_V;
            end
        end else if (w_clr_en) begin
            r_ctr[r_ptr] <= INIT_V;
        end else if (w_upd_en) begin
            r_ctr[bus.upd_idx] <= w_upd_new;
        end
    end

`ifdef BPT_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    // Shift in via a widened concat so IDX_W=1 needs no special case
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_enter_clr) begin
            r_ghr <= '0;
        end else if (w_upd_en) begin
            r_ghr <= IDX_W'({r_ghr, bus.upd_taken});
        end
    end

    assign w_lookup_idx = bus.read_idx ^ r_ghr;
`else
    assign w_lookup_idx = bus.read_idx;
`endif

    assign w_pred_ctr     = (r_state == S_CLEAR) ? '0 : r_ctr[w_lookup_idx];
    assign bus.pred_idx   = w_lookup_idx;
    assign bus.pred_ctr   = w_pred_ctr;
    assign bus.prediction = w_pred_ctr[CTR_W-1];
    assign bus.busy       = (r_state == S_CLEAR);
endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed testbench for branch_predictor_table (default build).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_branch_predictor_table;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_predictor_table_if #(.IDX_W(5), .CTR_W(2)) bus ();

    branch_predictor_table #(
        .ENTRIES(32),
        .CTR_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.read_idx  = '0;
        bus.upd_valid = 1'b0;
        bus.upd_idx   = '0;
        bus.upd_taken = 1'b0;
        bus.clear     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        for (int i = 0; i < 32; i++) begin
            bus.read_idx = 5'(i);
            #1;
            checks++;
            if (bus.pred_ctr !== 2'b01 || bus.prediction !== 1'b0) begin
                errors++;
                $display("FAIL reset_entry %0d got ctr=%b pred=%b want 01/0",
                         i, bus.pred_ctr, bus.prediction);
            end
            checks++;
            if (bus.pred_idx !== 5'(i)) begin
                errors++;
                $display("FAIL reset_pred_idx got %0d want %0d", bus.pred_idx, i);
            end
        end
        tick();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_t [3];
        logic [1:0] exp_n [4];
        exp_t = '{2'b10, 2'b11, 2'b11};
        exp_n = '{2'b10, 2'b01, 2'b00, 2'b00};
        bus.read_idx  = 5'd5;
        bus.upd_idx   = 5'd5;
        bus.upd_valid = 1'b1;
        bus.upd_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.pred_ctr !== exp_t[k] || bus.prediction !== exp_t[k][1]) begin
                errors++;
                $display("FAIL sat_taken step %0d got ctr=%b pred=%b want %b",
                         k, bus.pred_ctr, bus.prediction, exp_t[k]);
            end
        end
        bus.upd_taken = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.pred_ctr !== exp_n[k] || bus.prediction !== exp_n[k][1]) begin
                errors++;
                $display("FAIL sat_not_taken step %0d got ctr=%b pred=%b want %b",
                         k, bus.pred_ctr, bus.prediction, exp_n[k]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_collision();
        bus.read_idx  = 5'd7;
        bus.upd_idx   = 5'd7;
        bus.upd_valid = 1'b1;
        bus.upd_taken = 1'b1;
        #1;
        checks++;
        if (bus.prediction !== 1'b0 || bus.pred_ctr !== 2'b01) begin
            errors++;
            $display("FAIL collision_same_cycle got ctr=%b pred=%b want 01/0",
                     bus.pred_ctr, bus.prediction);
        end
        tick();
        bus.upd_valid = 1'b0;
        #1;
        checks++;
        if (bus.prediction !== 1'b1 || bus.pred_ctr !== 2'b10) begin
            errors++;
            $display("FAIL collision_next_cycle got ctr=%b pred=%b want 10/1",
                     bus.pred_ctr, bus.prediction);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        bus.upd_valid = 1'b1;
        bus.upd_taken = 1'b1;
        bus.upd_idx   = 5'd1;
        tick();
        bus.upd_idx = 5'd2;
        tick();
        bus.upd_idx = 5'd1;
        tick();
        idle_inputs();
        bus.read_idx = 5'd1;
        #1;
        checks++;
        if (bus.pred_ctr !== 2'b11) begin
            errors++;
            $display("FAIL b2b_idx1 got %b want 11", bus.pred_ctr);
        end
        bus.read_idx = 5'd2;
        #1;
        checks++;
        if (bus.pred_ctr !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idx2 got %b want 10", bus.pred_ctr);
        end
        tick();
    endtask

    task automatic test_clear();
        bus.upd_valid = 1'b1;
        bus.upd_taken = 1'b1;
        bus.upd_idx   = 5'd3;
        tick();
        tick();
        idle_inputs();
        bus.read_idx = 5'd3;
        #1;
        checks++;
        if (bus.pred_ctr !== 2'b11) begin
            errors++;
            $display("FAIL clear_train got %b want 11", bus.pred_ctr);
        end
        bus.clear = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy_early got %b want 0", bus.busy);
        end
        tick();
        bus.clear = 1'b0;
        for (int k = 0; k < 32; k++) begin
            bus.upd_valid = (k == 20);
            bus.upd_idx   = 5'd9;
            bus.upd_taken = 1'b1;
            bus.clear     = (k == 25);
            #1;
            checks++;
            if (bus.busy !== 1'b1 || bus.prediction !== 1'b0 || bus.pred_ctr !== 2'b00) begin
                errors++;
                $display("FAIL clear_sweep cycle %0d got busy=%b pred=%b ctr=%b want 1/0/00",
                         k, bus.busy, bus.prediction, bus.pred_ctr);
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_busy got %b want 0", bus.busy);
        end
        bus.read_idx = 5'd3;
        #1;
        checks++;
        if (bus.pred_ctr !== 2'b01) begin
            errors++;
            $display("FAIL clear_idx3 got %b want 01", bus.pred_ctr);
        end
        bus.read_idx = 5'd9;
        #1;
        checks++;
        if (bus.pred_ctr !== 2'b01) begin
            errors++;
            $display("FAIL clear_lost_update got %b want 01", bus.pred_ctr);
        end
        bus.read_idx = 5'd1;
        #1;
        checks++;
        if (bus.pred_ctr !== 2'b01) begin
            errors++;
            $display("FAIL clear_idx1 got %b want 01", bus.pred_ctr);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_restart got %b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bus.upd_valid = 1'b1;
        bus.upd_taken = 1'b1;
        bus.upd_idx   = 5'd12;
        tick();
        bus.upd_idx = 5'd30;
        tick();
        idle_inputs();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_busy got %b want 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy got %b want 0", bus.busy);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.read_idx = 5'(i);
            #1;
            checks++;
            if (bus.pred_ctr !== 2'b01) begin
                errors++;
                $display("FAIL midreset_entry %0d got %b want 01", i, bus.pred_ctr);
            end
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got %b want 0", bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_saturate();
        test_collision();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
